// File: rtl/bram_write_arbiter_pkg.sv
// Shared constants and types for the BRAM write arbiter.
// Holds the default frame geometry, the bus widths and the arbitration mode encoding.
package bram_write_arbiter_pkg;

  localparam int DEF_ADDR_W       = 19;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FRAME_PIXELS = 640 * 480;
  localparam int STAT_W           = 32;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/bram_write_arbiter_grant_sel.sv
// One-hot grant selector over the per-channel hold registers.
// Fixed mode: the lowest index wins. RR mode: the search starts one past ptr.
module arb_grant_sel
  import bram_write_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (mode == ARB_RR) ? (int'(ptr) + 1 + k) % N : k;
      if (!found && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_write_arbiter.sv
// Merges NUM_CH write requesters onto one registered BRAM write port; channel 0 is the pixel stream.
// Per-channel write counters exist only when WR_ARB_STATS_EN is defined.
module bram_write_arbiter
  import bram_write_arbiter_pkg::*;
#(
  parameter  int NUM_CH       = 2,
  parameter  int ADDR_W       = DEF_ADDR_W,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter  int ROUND_ROBIN  = 0,
  localparam int CH_W         = $clog2(NUM_CH)
)(
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_data,
  input  logic                       stream_restart,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [CH_W-1:0]            wr_ch,
  output logic [ADDR_W-1:0]          stream_addr,
  output logic                       frame_done,
  output logic                       frame_loaded,
  output logic [NUM_CH*STAT_W-1:0]   stat_count
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam arb_mode_e         MODE     = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;

  logic [NUM_CH-1:0]             hold_vld;
  logic [NUM_CH-1:0][ADDR_W-1:0] hold_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] hold_data;
  logic [NUM_CH-1:0]             grant;
  logic [NUM_CH-1:0]             accept;
  logic [CH_W-1:0]               gnt_idx;
  logic [CH_W-1:0]               rr_ptr;
  logic [ADDR_W-1:0]             stream_cap;

  arb_grant_sel #(.N(NUM_CH)) u_sel (
    .req   (hold_vld),
    .ptr   (rr_ptr),
    .mode  (MODE),
    .grant (grant)
  );

  // A hold being drained this cycle can take a new entry, giving back-to-back streaming.
  assign req_ready  = reset ? '0 : (~hold_vld | grant);
  assign accept     = req_valid & req_ready;
  assign stream_cap = stream_restart ? '0 : stream_addr;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) gnt_idx = CH_W'(i);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_vld  <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          hold_vld[i]  <= 1'b1;
          hold_addr[i] <= (i == 0) ? stream_cap : req_addr[i*ADDR_W +: ADDR_W];
          hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_ch   <= '0;
      rr_ptr  <= '0;
    end else begin
      wr_en <= |grant;
      if (|grant) begin
        wr_addr <= hold_addr[gnt_idx];
        wr_data <= hold_data[gnt_idx];
        wr_ch   <= gnt_idx;
        rr_ptr  <= gnt_idx;
      end
    end
  end

  // Restart beats the increment: the restarting pixel takes address 0, so the next one is 1.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stream_addr  <= '0;
      frame_done   <= 1'b0;
      frame_loaded <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept[0]) begin
        if (stream_restart) begin
          stream_addr <= ADDR_W'(1);
        end else if (stream_addr == LAST_PIX) begin
          stream_addr  <= '0;
          frame_done   <= 1'b1;
          frame_loaded <= 1'b1;
        end else begin
          stream_addr <= stream_addr + 1'b1;
        end
      end else if (stream_restart) begin
        stream_addr <= '0;
      end
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [NUM_CH-1:0][STAT_W-1:0] stat_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      stat_q <= '0;
    else if (|grant && stat_q[gnt_idx] != {STAT_W{1'b1}})
      stat_q[gnt_idx] <= stat_q[gnt_idx] + 1'b1;
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule
